// File: rtl/pet_mem_decode_ctl.sv
// PET memory-map decoder plus a Wishbone B4 pipelined slave that runs
// single-byte read/write cycles on the shared asynchronous SRAM.
// The decoder is purely combinational; the RAM controller is a small FSM
// whose outputs are all registered.
module pet_mem_decode_ctl #(
    parameter int unsigned RAM_ADDR_WIDTH  = 17,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned CPU_ADDR_WIDTH  = 16,
    parameter int unsigned RD_WAIT_CYCLES  = 2,
    parameter int unsigned WE_PULSE_CYCLES = 2
) (
    input  logic                      wb_clock_i,
    input  logic                      wb_reset_i,
    input  logic [RAM_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    input  logic                      wb_we_i,
    input  logic                      wb_cycle_i,
    input  logic                      wb_strobe_i,
    output logic                      wb_stall_o,
    output logic                      wb_ack_o,
    output logic                      ram_oe_o,
    output logic                      ram_we_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0]     ram_data_i,
    output logic [DATA_WIDTH-1:0]     ram_data_o,
    output logic                      ram_data_oe,
    input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr_i,
    output logic                      ram_en_o,
    output logic                      io_en_o,
    output logic                      pia1_en_o,
    output logic                      pia2_en_o,
    output logic                      via_en_o
);

    // Counter only needs to reach the longer of the two wait/pulse counts.
    localparam int unsigned CNT_MAX = (RD_WAIT_CYCLES > WE_PULSE_CYCLES - 1) ?
                                      RD_WAIT_CYCLES : WE_PULSE_CYCLES - 1;
    localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT_CYCLES);
    localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_PULSE_CYCLES - 1);

    // The arbiter relies on every transaction acking within 6 clocks of
    // acceptance; refuse parameter sets that would break that promise.
    if (RD_WAIT_CYCLES + 2 > 6 || WE_PULSE_CYCLES + 3 > 6 || WE_PULSE_CYCLES < 1)
    begin : g_bad_timing
        $error("pet_mem_decode_ctl: wait/pulse parameters exceed the 6-clock ack bound");
    end

    // ------------------------------------------------------------------
    // Address decoder
    // ------------------------------------------------------------------
    logic io_page;
    logic unused_cpu_addr;

    assign io_page   = (cpu_addr_i[CPU_ADDR_WIDTH-1 -: 8] == 8'hE8);
    assign io_en_o   = io_page;
    assign ram_en_o  = ~io_page;
    // Partial decode: the chips overlap deliberately, $E870 hits all three.
    assign pia1_en_o = io_page & cpu_addr_i[4];
    assign pia2_en_o = io_page & cpu_addr_i[5];
    assign via_en_o  = io_page & cpu_addr_i[6];

    assign unused_cpu_addr = ^{cpu_addr_i[7], cpu_addr_i[3:0]};

    // ------------------------------------------------------------------
    // SRAM cycle controller
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWriteSetup,
        StWritePulse,
        StWriteHold
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic                      accept;
    logic                      rd_done;
    logic                      wr_done;
    logic                      stall_d;
    logic                      ack_d;
    logic                      oe_d;
    logic                      we_d;
    logic                      data_oe_d;
    logic [DATA_WIDTH-1:0]     rdata_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0]     wdata_d;

    assign accept  = (state_q == StIdle) & wb_cycle_i & wb_strobe_i & ~wb_stall_o;
    assign rd_done = (state_q == StRead) & (cnt_q == RD_LAST);
    assign wr_done = (state_q == StWriteHold);

    // State register and registered outputs; reset aborts any cycle in flight.
    always_ff @(posedge wb_clock_i) begin
        if (!wb_reset_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wb_stall_o  <= 1'b0;
            wb_ack_o    <= 1'b0;
            ram_oe_o    <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_data_oe <= 1'b0;
            wb_data_o   <= '0;
            ram_addr_o  <= '0;
            ram_data_o  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_stall_o  <= stall_d;
            wb_ack_o    <= ack_d;
            ram_oe_o    <= oe_d;
            ram_we_o    <= we_d;
            ram_data_oe <= data_oe_d;
            wb_data_o   <= rdata_d;
            ram_addr_o  <= addr_d;
            ram_data_o  <= wdata_d;
        end
    end

    // Next-state logic; the counter is reused for read wait and WE pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = wb_we_i ? StWriteSetup : StRead;
                end
            end
            StRead: begin
                if (cnt_q == RD_LAST) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWriteSetup: begin
                cnt_d   = '0;
                state_d = StWritePulse;
            end
            StWritePulse: begin
                if (cnt_q == WE_LAST) begin
                    state_d = StWriteHold;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWriteHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output next-values, derived from the upcoming state so they register
    // in step with it; oe and we/data_oe come from disjoint states.
    always_comb begin
        stall_d   = (state_d != StIdle);
        oe_d      = (state_d == StRead);
        we_d      = (state_d == StWritePulse);
        data_oe_d = (state_d == StWriteSetup) || (state_d == StWritePulse) ||
                    (state_d == StWriteHold);
        // RAM cycle always finishes, but a master that dropped CYC gets no ack.
        ack_d     = (rd_done | wr_done) & wb_cycle_i;
        rdata_d   = rd_done ? ram_data_i : wb_data_o;
        addr_d    = accept ? wb_addr_i : ram_addr_o;
        wdata_d   = (accept & wb_we_i) ? wb_data_i : ram_data_o;
    end

endmodule

// File: tb/tb_pet_mem_decode_ctl.sv
// Directed self-checking bench for pet_mem_decode_ctl.
module tb_pet_mem_decode_ctl;

    logic        clk = 1'b0;
    logic        wb_reset;
    logic [16:0] wb_addr;
    logic [7:0]  wb_wdata;
    logic [7:0]  wb_rdata;
    logic        wb_we;
    logic        wb_cycle;
    logic        wb_strobe;
    logic        wb_stall;
    logic        wb_ack;
    logic        ram_oe;
    logic        ram_we;
    logic [16:0] ram_addr;
    logic [7:0]  ram_rdata;
    logic [7:0]  ram_wdata;
    logic        ram_data_oe;
    logic [15:0] cpu_addr;
    logic        ram_en, io_en, pia1_en, pia2_en, via_en;

    // SRAM model: data is only valid while the controller enables the output.
    logic [7:0]  sram_val;
    assign ram_rdata = ram_oe ? sram_val : 8'hFF;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pet_mem_decode_ctl dut (
        .wb_clock_i  (clk),
        .wb_reset_i  (wb_reset),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_wdata),
        .wb_data_o   (wb_rdata),
        .wb_we_i     (wb_we),
        .wb_cycle_i  (wb_cycle),
        .wb_strobe_i (wb_strobe),
        .wb_stall_o  (wb_stall),
        .wb_ack_o    (wb_ack),
        .ram_oe_o    (ram_oe),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_data_i  (ram_rdata),
        .ram_data_o  (ram_wdata),
        .ram_data_oe (ram_data_oe),
        .cpu_addr_i  (cpu_addr),
        .ram_en_o    (ram_en),
        .io_en_o     (io_en),
        .pia1_en_o   (pia1_en),
        .pia2_en_o   (pia2_en),
        .via_en_o    (via_en)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request at a negedge; return at the negedge after acceptance.
    task automatic start_txn(input logic we, input logic [16:0] addr, input logic [7:0] data);
        @(negedge clk);
        wb_cycle  = 1'b1;
        wb_strobe = 1'b1;
        wb_we     = we;
        wb_addr   = addr;
        wb_wdata  = data;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Record output waveforms for samples k=0..6 after the accepting edge.
    task automatic capture(input bit drop_cyc, output logic [6:0] oe, output logic [6:0] we,
                           output logic [6:0] doe, output logic [6:0] stall,
                           output logic [6:0] ack, output int overlap);
        oe = '0; we = '0; doe = '0; stall = '0; ack = '0; overlap = 0;
        for (int k = 0; k < 7; k++) begin
            oe[k]    = ram_oe;
            we[k]    = ram_we;
            doe[k]   = ram_data_oe;
            stall[k] = wb_stall;
            ack[k]   = wb_ack;
            if (ram_oe && (ram_we || ram_data_oe)) overlap++;
            if (k == 0) begin
                wb_strobe = 1'b0;
                if (drop_cyc) wb_cycle = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        wb_cycle = 1'b0;
    endtask

    // Decoder vectors: expected {ram, io, pia1, pia2, via}.
    logic [15:0] dec_addr [11] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hE7FF, 16'hE900,
                                   16'hFFFF, 16'hE810, 16'hE820, 16'hE840, 16'hE800,
                                   16'hE870};
    logic [4:0]  dec_exp  [11] = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000,
                                   5'b10000, 5'b01100, 5'b01010, 5'b01001, 5'b01000,
                                   5'b01111};

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] p_oe, p_we, p_doe, p_stall, p_ack;
        int         ovl;
        int         acks, idx, ack_c0, ack_c1;
        int         acc_c [2];
        bit         will_accept;

        wb_reset  = 1'b0;
        wb_addr   = '0;
        wb_wdata  = '0;
        wb_we     = 1'b0;
        wb_cycle  = 1'b0;
        wb_strobe = 1'b0;
        cpu_addr  = '0;
        sram_val  = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", {wb_ack, wb_stall, ram_oe, ram_we, ram_data_oe}, 5'b00000);
        check("rst_rdata", wb_rdata, 8'h00);
        check("rst_addr", ram_addr, 17'h0);
        check("rst_wdata", ram_wdata, 8'h00);
        wb_reset = 1'b1;

        // Decoder
        for (int i = 0; i < 11; i++) begin
            cpu_addr = dec_addr[i];
            #1;
            check($sformatf("dec_%04h", dec_addr[i]), {ram_en, io_en, pia1_en, pia2_en, via_en},
                  dec_exp[i]);
        end

        // Write $1ABCD <= $5A
        start_txn(1'b1, 17'h1ABCD, 8'h5A);
        check("wr_addr", ram_addr, 17'h1ABCD);
        check("wr_data", ram_wdata, 8'h5A);
        capture(1'b0, p_oe, p_we, p_doe, p_stall, p_ack, ovl);
        check("wr_we_pat", p_we, 7'b0000110);
        check("wr_doe_pat", p_doe, 7'b0001111);
        check("wr_stall_pat", p_stall, 7'b0001111);
        check("wr_ack_pat", p_ack, 7'b0010000);
        check("wr_oe_pat", p_oe, 7'b0000000);
        check("wr_overlap", ovl, 0);
        check("wr_keeps_rdata", wb_rdata, 8'h00);

        // Read $1ABCD, SRAM returns $5A
        sram_val = 8'h5A;
        start_txn(1'b0, 17'h1ABCD, 8'h00);
        check("rd_addr", ram_addr, 17'h1ABCD);
        capture(1'b0, p_oe, p_we, p_doe, p_stall, p_ack, ovl);
        check("rd_oe_pat", p_oe, 7'b0000111);
        check("rd_ack_pat", p_ack, 7'b0001000);
        check("rd_stall_pat", p_stall, 7'b0000111);
        check("rd_we_doe", {p_we, p_doe}, 14'h0);
        check("rd_data", wb_rdata, 8'h5A);

        // Later write must not disturb the read data
        start_txn(1'b1, 17'h00001, 8'h33);
        capture(1'b0, p_oe, p_we, p_doe, p_stall, p_ack, ovl);
        check("wr2_ack_pat", p_ack, 7'b0010000);
        check("wr2_rdata_hold", wb_rdata, 8'h5A);
        check("wr2_addr", ram_addr, 17'h00001);
        check("wr2_data", ram_wdata, 8'h33);

        // STB without CYC is ignored
        @(negedge clk);
        wb_strobe = 1'b1;
        wb_cycle  = 1'b0;
        wb_we     = 1'b0;
        repeat (3) @(negedge clk);
        check("stb_only", {wb_stall, ram_oe, ram_data_oe, wb_ack}, 4'b0000);
        wb_strobe = 1'b0;

        // Back-to-back: write presented while the read's ack is out
        sram_val = 8'hA5;
        acks = 0; idx = 0; ack_c0 = -1; ack_c1 = -1;
        acc_c[0] = -1; acc_c[1] = -1;
        will_accept = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            if (wb_ack) begin
                acks++;
                if (ack_c0 < 0) ack_c0 = c;
                else ack_c1 = c;
            end
            if (will_accept) idx++;
            if (idx == 0) begin
                wb_cycle = 1'b1; wb_strobe = 1'b1; wb_we = 1'b0;
                wb_addr = 17'h00010; wb_wdata = 8'h00;
            end else if (idx == 1) begin
                wb_cycle = 1'b1; wb_strobe = 1'b1; wb_we = 1'b1;
                wb_addr = 17'h00020; wb_wdata = 8'h3C;
            end else begin
                wb_strobe = 1'b0;
            end
            will_accept = wb_strobe && !wb_stall;
            if (will_accept) acc_c[idx] = c;
            @(posedge clk);
            @(negedge clk);
        end
        wb_cycle = 1'b0;
        check("b2b_acks", acks, 2);
        check("b2b_accepts", idx, 2);
        check("b2b_rd_acc", acc_c[0], 0);
        check("b2b_rd_ack", ack_c0, 4);
        check("b2b_wr_acc", acc_c[1], 4);
        check("b2b_wr_ack", ack_c1, 9);
        check("b2b_rdata", wb_rdata, 8'hA5);
        check("b2b_wr", {ram_addr, ram_wdata}, {17'h00020, 8'h3C});

        // Reset asserted during the WE pulse
        start_txn(1'b1, 17'h00444, 8'hC3);
        wb_strobe = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pulse_we", ram_we, 1'b1);
        wb_reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_ctl", {ram_we, ram_data_oe, wb_stall, wb_ack, ram_oe}, 5'b00000);
        check("rstmid_addr", ram_addr, 17'h0);
        wb_reset = 1'b1;
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (wb_ack) acks++;
        end
        check("rstmid_noack", acks, 0);
        wb_cycle = 1'b0;

        // CYC dropped mid-read: RAM cycle completes, ack suppressed
        sram_val = 8'h77;
        start_txn(1'b0, 17'h00100, 8'h00);
        capture(1'b1, p_oe, p_we, p_doe, p_stall, p_ack, ovl);
        check("drop_ack", p_ack, 7'b0000000);
        check("drop_oe_pat", p_oe, 7'b0000111);
        check("drop_stall_pat", p_stall, 7'b0000111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
